// File: rtl/pe_agu_seq_pkg.sv
// Shared AGU definitions: instruction descriptor, mode encodings, sequencer states, bw().
package GLOBAL_PARAM;

  localparam int unsigned AGU_INST_W = 25;

  // 'release' is a reserved word, so the bank-release flag is stored as 'rel'
  typedef struct packed {
    logic [1:0] mode;
    logic [7:0] idx_cnt;
    logic [7:0] trip_cnt;
    logic       is_new;
    logic [3:0] pad_code;
    logic       cut_y;
    logic       rel;
  } agu_inst_t;

  localparam logic [1:0] MODE_CONV_A = 2'b00;
  localparam logic [1:0] MODE_FC_A   = 2'b01;
  localparam logic [1:0] MODE_CONV_B = 2'b10;
  localparam logic [1:0] MODE_FC_B   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SWITCH    = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_LOW  = 3'd3,
    S_WAIT_DONE = 3'd4
  } seq_state_t;

  function automatic int unsigned bw(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic is_fc_mode(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/pe_agu_seq_inst_fifo.sv
// Synchronous FIFO of AGU instruction descriptors; depth must be a power of two.
module pe_agu_inst_fifo
  import GLOBAL_PARAM::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_push,
  input  agu_inst_t i_data,
  input  logic      i_pop,
  output agu_inst_t o_data,
  output logic      o_full,
  output logic      o_empty
);

  localparam int unsigned AW = bw(DEPTH);

  agu_inst_t     r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign w_do_pop  = i_pop && !o_empty;
  // a push into a full FIFO is allowed when the head leaves in the same cycle
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/pe_agu_seq.sv
// Per-PE AGU instruction sequencer with index-bank ping-pong tracking.
// Optional performance counters are enabled by defining PE_AGU_SEQ_PERF_EN.
module pe_agu_seq
  import GLOBAL_PARAM::*;
#(
  parameter int unsigned INST_DEPTH = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [1:0]  inst_mode,
  input  logic [7:0]  inst_idx_cnt,
  input  logic [7:0]  inst_trip_cnt,
  input  logic        inst_is_new,
  input  logic [3:0]  inst_pad_code,
  input  logic        inst_cut_y,
  input  logic        inst_release,
  input  logic        idx_load_done,
  output logic        idx_load_ready,
  output logic        agu_start,
  output logic [1:0]  agu_mode,
  output logic [7:0]  agu_idx_cnt,
  output logic [7:0]  agu_trip_cnt,
  output logic        agu_is_new,
  output logic [3:0]  agu_pad_code,
  output logic        agu_cut_y,
  input  logic        agu_done,
  output logic        switch_idx_buf,
  output logic        busy,
  output logic [15:0] inst_issued
`ifdef PE_AGU_SEQ_PERF_EN
  ,
  input  logic             perf_clr,
  output logic [CNT_W-1:0] perf_busy_cyc,
  output logic [CNT_W-1:0] perf_idx_stall_cyc,
  output logic [CNT_W-1:0] perf_inst_stall_cyc
`endif
);

  if ((INST_DEPTH < 2) || ((INST_DEPTH & (INST_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("pe_agu_seq: INST_DEPTH must be a power of two >= 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pe_agu_seq: CNT_W must be at least 1");
  end

  seq_state_t r_state;
  seq_state_t w_next;

  agu_inst_t  w_push_data;
  agu_inst_t  w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;

  logic       r_wr_full;
  logic       r_rd_full;
  logic       r_agu_start;
  logic       r_switch;
  agu_inst_t  r_agu_inst;
  logic [15:0] r_issued;

  assign w_push_data = '{mode:     inst_mode,
                         idx_cnt:  inst_idx_cnt,
                         trip_cnt: inst_trip_cnt,
                         is_new:   inst_is_new,
                         pad_code: inst_pad_code,
                         cut_y:    inst_cut_y,
                         rel:      inst_release};
  assign w_push = inst_valid && !w_full;

  pe_agu_inst_fifo #(
    .DEPTH (INST_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rd_full && r_wr_full)                w_next = S_SWITCH;
        else if (r_rd_full && !w_empty && agu_done) w_next = S_ISSUE;
      end
      S_SWITCH:   w_next = S_IDLE;
      S_ISSUE: begin
        w_pop  = 1'b1;
        w_next = S_WAIT_LOW;
      end
      // the AGU needs a cycle to drop done after start, so it is not sampled here
      S_WAIT_LOW: w_next = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (agu_done) w_next = S_IDLE;
      end
      default:    w_next = S_IDLE;
    endcase
  end

  // start/switch/fields are launched from the next-state so they line up with the state itself
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_agu_start <= 1'b0;
      r_switch    <= 1'b0;
      r_agu_inst  <= '0;
      r_issued    <= '0;
    end else begin
      r_agu_start <= (w_next == S_ISSUE);
      r_switch    <= (w_next == S_SWITCH);
      if (w_next == S_ISSUE) begin
        r_agu_inst <= w_head;
        r_issued   <= r_issued + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_full <= 1'b0;
      r_rd_full <= 1'b0;
    end else begin
      if (r_switch)                        r_wr_full <= 1'b0;
      else if (idx_load_done && !r_wr_full) r_wr_full <= 1'b1;

      if (r_switch)
        r_rd_full <= 1'b1;
      else if ((r_state == S_WAIT_DONE) && agu_done && r_agu_inst.rel)
        r_rd_full <= 1'b0;
    end
  end

  assign inst_ready     = !w_full;
  assign idx_load_ready = !r_wr_full;
  assign agu_start      = r_agu_start;
  assign switch_idx_buf = r_switch;
  assign agu_mode       = r_agu_inst.mode;
  assign agu_idx_cnt    = r_agu_inst.idx_cnt;
  assign agu_trip_cnt   = r_agu_inst.trip_cnt;
  assign agu_is_new     = r_agu_inst.is_new;
  assign agu_pad_code   = r_agu_inst.pad_code;
  assign agu_cut_y      = r_agu_inst.cut_y;
  assign busy           = (r_state != S_IDLE) || !w_empty;
  assign inst_issued    = r_issued;

`ifdef PE_AGU_SEQ_PERF_EN
  logic [CNT_W-1:0] r_perf_busy;
  logic [CNT_W-1:0] r_perf_idx_stall;
  logic [CNT_W-1:0] r_perf_inst_stall;
  logic             w_cnt_busy;
  logic             w_cnt_idx_stall;
  logic             w_cnt_inst_stall;

  assign w_cnt_busy       = (r_state == S_ISSUE) || (r_state == S_WAIT_LOW) ||
                            (r_state == S_WAIT_DONE);
  assign w_cnt_idx_stall  = (r_state == S_IDLE) && !w_empty && !r_rd_full;
  assign w_cnt_inst_stall = (r_state == S_IDLE) && w_empty && r_rd_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_busy       <= '0;
      r_perf_idx_stall  <= '0;
      r_perf_inst_stall <= '0;
    end else if (perf_clr) begin
      r_perf_busy       <= '0;
      r_perf_idx_stall  <= '0;
      r_perf_inst_stall <= '0;
    end else begin
      if (w_cnt_busy && (r_perf_busy != '1))
        r_perf_busy <= r_perf_busy + CNT_W'(1);
      if (w_cnt_idx_stall && (r_perf_idx_stall != '1))
        r_perf_idx_stall <= r_perf_idx_stall + CNT_W'(1);
      if (w_cnt_inst_stall && (r_perf_inst_stall != '1))
        r_perf_inst_stall <= r_perf_inst_stall + CNT_W'(1);
    end
  end

  assign perf_busy_cyc       = r_perf_busy;
  assign perf_idx_stall_cyc  = r_perf_idx_stall;
  assign perf_inst_stall_cyc = r_perf_inst_stall;
`endif

endmodule

// File: tb/tb_pe_agu_seq.sv
// Directed bench for pe_agu_seq with a simple AGU done-level model.
module tb_pe_agu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic [1:0]  inst_mode = '0;
  logic [7:0]  inst_idx_cnt = '0;
  logic [7:0]  inst_trip_cnt = '0;
  logic        inst_is_new = 1'b0;
  logic [3:0]  inst_pad_code = '0;
  logic        inst_cut_y = 1'b0;
  logic        inst_release = 1'b0;
  logic        idx_load_done = 1'b0;
  logic        idx_load_ready;
  logic        agu_start;
  logic [1:0]  agu_mode;
  logic [7:0]  agu_idx_cnt;
  logic [7:0]  agu_trip_cnt;
  logic        agu_is_new;
  logic [3:0]  agu_pad_code;
  logic        agu_cut_y;
  logic        agu_done;
  logic        switch_idx_buf;
  logic        busy;
  logic [15:0] inst_issued;
`ifdef PE_AGU_SEQ_PERF_EN
  logic        perf_clr = 1'b0;
  logic [31:0] perf_busy_cyc;
  logic [31:0] perf_idx_stall_cyc;
  logic [31:0] perf_inst_stall_cyc;
`endif

  always #5 clk = ~clk;

  pe_agu_seq #(
    .INST_DEPTH (4),
    .CNT_W      (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_mode      (inst_mode),
    .inst_idx_cnt   (inst_idx_cnt),
    .inst_trip_cnt  (inst_trip_cnt),
    .inst_is_new    (inst_is_new),
    .inst_pad_code  (inst_pad_code),
    .inst_cut_y     (inst_cut_y),
    .inst_release   (inst_release),
    .idx_load_done  (idx_load_done),
    .idx_load_ready (idx_load_ready),
    .agu_start      (agu_start),
    .agu_mode       (agu_mode),
    .agu_idx_cnt    (agu_idx_cnt),
    .agu_trip_cnt   (agu_trip_cnt),
    .agu_is_new     (agu_is_new),
    .agu_pad_code   (agu_pad_code),
    .agu_cut_y      (agu_cut_y),
    .agu_done       (agu_done),
    .switch_idx_buf (switch_idx_buf),
    .busy           (busy),
    .inst_issued    (inst_issued)
`ifdef PE_AGU_SEQ_PERF_EN
    ,
    .perf_clr            (perf_clr),
    .perf_busy_cyc       (perf_busy_cyc),
    .perf_idx_stall_cyc  (perf_idx_stall_cyc),
    .perf_inst_stall_cyc (perf_inst_stall_cyc)
`endif
  );

  // AGU model: done drops the cycle after start and returns agu_lat cycles later
  int agu_lat = 10;
  int agu_cnt = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      agu_done <= 1'b1;
      agu_cnt  <= 0;
    end else if (agu_start) begin
      agu_done <= 1'b0;
      agu_cnt  <= agu_lat;
    end else if (agu_cnt > 0) begin
      agu_cnt <= agu_cnt - 1;
      if (agu_cnt == 1) agu_done <= 1'b1;
    end
  end

  int   cyc = 0;
  int   n_start = 0;
  int   n_switch = 0;
  int   last_sw_cyc = 0;
  int   last_rise_cyc = 0;
  logic prev_done = 1'b1;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (agu_start)      n_start = n_start + 1;
    if (switch_idx_buf) begin
      n_switch    = n_switch + 1;
      last_sw_cyc = cyc;
    end
    if (agu_done && !prev_done) last_rise_cyc = cyc;
    prev_done = agu_done;
  end

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic rel, input logic [7:0] idx);
    inst_valid    = 1'b1;
    inst_release  = rel;
    inst_idx_cnt  = idx;
    inst_mode     = ~idx[1:0];
    inst_trip_cnt = idx + 8'd1;
    inst_is_new   = ~idx[0];
    inst_pad_code = idx[3:0] ^ 4'h5;
    inst_cut_y    = ~idx[1];
    tick();
    inst_valid    = 1'b0;
  endtask

  task automatic load();
    idx_load_done = 1'b1;
    tick();
    idx_load_done = 1'b0;
  endtask

  task automatic wait_start(input int budget, output int k);
    k = 0;
    while (!agu_start && k < budget) begin
      tick();
      k++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    tick(2);
    check("rst busy", busy, 0);
    check("rst inst_ready", inst_ready, 1);
    check("rst idx_load_ready", idx_load_ready, 1);
    check("rst agu_start", agu_start, 0);
    check("rst switch", switch_idx_buf, 0);
    check("rst idx_cnt", agu_idx_cnt, 0);
    check("rst issued", inst_issued, 0);
    rst = 1'b1;
    tick();

    // single instruction on a freshly loaded bank
    load();
    check("t1 load_ready low", idx_load_ready, 0);
    check("t1 no switch yet", switch_idx_buf, 0);
    tick();
    check("t1 switch N+2", switch_idx_buf, 1);
    tick();
    check("t1 switch 1 cycle", switch_idx_buf, 0);
    check("t1 load_ready back", idx_load_ready, 1);
    push(1'b1, 8'd8);
    check("t1 no start N+1", agu_start, 0);
    tick();
    check("t1 start N+2", agu_start, 1);
    check("t1 idx_cnt", agu_idx_cnt, 8);
    check("t1 mode", agu_mode, 2'd3);
    check("t1 trip", agu_trip_cnt, 9);
    check("t1 is_new", agu_is_new, 1);
    check("t1 pad", agu_pad_code, 4'hD);
    check("t1 cut_y", agu_cut_y, 1);
    check("t1 issued", inst_issued, 1);
    tick();
    check("t1 start pulse", agu_start, 0);
    tick(10);
    check("t1 busy in wait", busy, 1);
    tick();
    check("t1 idle after done", busy, 0);
    check("t1 fields held", agu_idx_cnt, 8);
    check("t1 one switch", n_switch, 1);

    // three instructions on one bank, release only on the last
    agu_lat = 3;
    push(1'b0, 8'd1);
    push(1'b0, 8'd2);
    push(1'b1, 8'd3);
    tick(3);
    check("t2 rd bank released", n_start, 1);
    check("t2 busy pending", busy, 1);
    load();
    wait_start(20, k);
    check("t2 start1", agu_start, 1);
    check("t2 idx1", agu_idx_cnt, 1);
    tick();
    wait_start(20, k);
    check("t2 start2", agu_start, 1);
    check("t2 idx2", agu_idx_cnt, 2);
    check("t2 b2b gap", k, 5);
    tick();
    wait_start(20, k);
    check("t2 start3", agu_start, 1);
    check("t2 idx3", agu_idx_cnt, 3);
    tick(8);
    check("t2 idle", busy, 0);
    check("t2 single switch", n_switch, 2);
    check("t2 issued", inst_issued, 4);

    // fill the FIFO with no bank loaded
    agu_lat = 10;
    for (int i = 0; i < 4; i++) begin
      check("t3 ready before push", inst_ready, 1);
      push((i == 0), 8'(10 + i));
    end
    check("t3 full", inst_ready, 0);
    inst_valid   = 1'b1;
    inst_idx_cnt = 8'd14;
    tick(2);
    inst_valid   = 1'b0;
    check("t3 still full", inst_ready, 0);
    check("t3 no start", n_start, 4);

    // second load lands while the first bank is in use
    load();
    wait_start(10, k);
    check("t4 start", agu_start, 1);
    check("t4 start latency", k, 3);
    check("t4 idx10", agu_idx_cnt, 10);
    tick(2);
    check("t4 load_ready in use", idx_load_ready, 1);
    load();
    check("t4 load accepted", idx_load_ready, 0);
    k = 0;
    while (!switch_idx_buf && k < 30) begin
      tick();
      k++;
    end
    check("t4 switch seen", switch_idx_buf, 1);
    #5;
    check("t4 switch after done", last_sw_cyc - last_rise_cyc, 2);
    check("t4 no early start", n_start, 5);
    #1;
    wait_start(10, k);
    check("t4 idx11", agu_idx_cnt, 11);

    // reset while waiting for done
    tick(3);
    check("t5 busy pre", busy, 1);
    rst = 1'b0;
    #1;
    check("t5 start", agu_start, 0);
    check("t5 switch", switch_idx_buf, 0);
    check("t5 busy", busy, 0);
    check("t5 inst_ready", inst_ready, 1);
    check("t5 load_ready", idx_load_ready, 1);
    check("t5 issued", inst_issued, 0);
    check("t5 idx_cnt", agu_idx_cnt, 0);
    check("t5 mode", agu_mode, 0);
    tick();
    rst = 1'b1;
    tick();
    push(1'b1, 8'd20);
    tick(8);
    check("t5 no start w/o load", n_start, 6);
    check("t5 pending", busy, 1);

`ifdef PE_AGU_SEQ_PERF_EN
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    check("perf cleared", perf_idx_stall_cyc, 0);
    tick(20);
    check("perf idx stall", perf_idx_stall_cyc, 20);
    check("perf inst stall", perf_inst_stall_cyc, 0);
    check("perf busy", perf_busy_cyc, 0);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    check("perf clr", perf_idx_stall_cyc, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
